// File: rtl/waveform_pkg.sv
`default_nettype none
// waveform_pkg: mode encoding and default widths shared by the DDS waveform generator.
// Rev 1.0
package waveform_pkg;

   localparam int DEF_ACC_WIDTH  = 32;
   localparam int DEF_FREQ_WIDTH = 23;
   localparam int DEF_OUT_WIDTH  = 8;
   localparam int DEF_AMP_WIDTH  = 8;

   typedef enum logic [1:0] {
      MODE_SAW_UP   = 2'd0,
      MODE_SAW_DOWN = 2'd1,
      MODE_TRIANGLE = 2'd2,
      MODE_SQUARE   = 2'd3
   } wave_mode_e;

endpackage
`default_nettype wire

// File: rtl/waveform_generator_phase_accumulator.sv
`default_nettype none
// phase_accumulator: modulo-2^ACC_WIDTH phase register with carry detect and wrap pulse.
// Rev 1.0
module phase_accumulator
   import waveform_pkg::*;
#(
   parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
   parameter int FREQ_WIDTH  = DEF_FREQ_WIDTH,
   parameter int PHASE_WIDTH = DEF_OUT_WIDTH + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   phase_sync,
   input  logic [FREQ_WIDTH-1:0]  freq_i,
   output logic [PHASE_WIDTH-1:0] phase_o,
   output logic                   carry_o,
   output logic                   wrap_o
);

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH:0]   sum;
   logic                 wrap_q, wrap_d;

   // One extra bit on the adder captures the carry-out that marks a period boundary.
   assign sum     = {1'b0, acc_q} + (ACC_WIDTH+1)'(freq_i);
   assign carry_o = enable & sum[ACC_WIDTH];

   always_comb begin
      acc_d  = acc_q;
      wrap_d = carry_o | phase_sync;
      if (phase_sync) begin
         acc_d = '0;
      end else if (enable) begin
         acc_d = sum[ACC_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         wrap_q <= wrap_d;
      end
   end

   assign phase_o = acc_q[ACC_WIDTH-1 -: PHASE_WIDTH];
   assign wrap_o  = wrap_q;

endmodule
`default_nettype wire

// File: rtl/waveform_generator.sv
`default_nettype none
// waveform_generator: four-shape DDS with double-buffered configuration and a
// two-stage shape/scale pipeline. Rev 1.0
module waveform_generator
   import waveform_pkg::*;
#(
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int FREQ_WIDTH = DEF_FREQ_WIDTH,
   parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
   parameter int AMP_WIDTH  = DEF_AMP_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  phase_sync,
   input  logic                  cfg_load,
   input  logic [FREQ_WIDTH-1:0] frequency,
   input  logic [AMP_WIDTH-1:0]  amplitude,
   input  logic [1:0]            mode,
   input  logic [OUT_WIDTH-1:0]  duty,
   output logic [OUT_WIDTH-1:0]  wave_out,
   output logic                  wave_valid,
   output logic                  wrap,
   output logic                  cfg_pending
);

   typedef struct packed {
      logic [FREQ_WIDTH-1:0] freq;
      logic [AMP_WIDTH-1:0]  amp;
      wave_mode_e            mode;
      logic [OUT_WIDTH-1:0]  duty;
   } cfg_t;

   localparam int   PROD_W     = OUT_WIDTH + AMP_WIDTH + 1;
   localparam cfg_t ACT_RESET  = '{freq: '0, amp: '0, mode: MODE_SAW_UP,
                                   duty: OUT_WIDTH'(1) << (OUT_WIDTH - 1)};

   cfg_t                 act_q, act_d, pend_q, pend_d, cfg_in;
   logic                 pend_flag_q, pend_flag_d;
   logic                 carry, apply;
   logic [OUT_WIDTH:0]   phase;
   logic [OUT_WIDTH-1:0] p_phase, t_phase;
   logic [OUT_WIDTH-1:0] shape_q, shape_d;
   logic [AMP_WIDTH-1:0] amp_q;
   logic [AMP_WIDTH:0]   gain;
   logic [PROD_W-1:0]    product;
   logic [OUT_WIDTH-1:0] wave_q, wave_d;
   logic [2:0]           en_q;

   phase_accumulator #(
      .ACC_WIDTH  (ACC_WIDTH),
      .FREQ_WIDTH (FREQ_WIDTH),
      .PHASE_WIDTH(OUT_WIDTH + 1)
   ) u_phase_accumulator (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .phase_sync(phase_sync),
      .freq_i    (act_q.freq),
      .phase_o   (phase),
      .carry_o   (carry),
      .wrap_o    (wrap)
   );

   assign cfg_in = '{freq: frequency, amp: amplitude, mode: wave_mode_e'(mode), duty: duty};

   // A stalled accumulator has no period to protect, so pending config may land at once.
   assign apply = pend_flag_q & (carry | phase_sync | ~enable);

   always_comb begin
      act_d       = act_q;
      pend_d      = pend_q;
      pend_flag_d = pend_flag_q;
      if (apply) begin
         act_d       = pend_q;
         pend_flag_d = 1'b0;
      end
      if (cfg_load) begin
         pend_d      = cfg_in;
         pend_flag_d = 1'b1;
      end
   end

   assign p_phase = phase[OUT_WIDTH:1];
   assign t_phase = phase[OUT_WIDTH-1:0];

   always_comb begin
      shape_d = p_phase;
      case (act_q.mode)
         MODE_SAW_UP:   shape_d = p_phase;
         MODE_SAW_DOWN: shape_d = ~p_phase;
         MODE_TRIANGLE: shape_d = phase[OUT_WIDTH] ? ~t_phase : t_phase;
         MODE_SQUARE:   shape_d = (p_phase < act_q.duty) ? '1 : '0;
         default:       shape_d = p_phase;
      endcase
   end

   // amp+1 makes all-ones exact unity without any post-scale correction.
   assign gain    = {1'b0, amp_q} + (AMP_WIDTH+1)'(1);
   assign product = PROD_W'(shape_q) * PROD_W'(gain);
   assign wave_d  = OUT_WIDTH'(product >> AMP_WIDTH);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_q       <= ACT_RESET;
         pend_q      <= '0;
         pend_flag_q <= 1'b0;
         shape_q     <= '0;
         amp_q       <= '0;
         wave_q      <= '0;
         en_q        <= '0;
      end else begin
         act_q       <= act_d;
         pend_q      <= pend_d;
         pend_flag_q <= pend_flag_d;
         shape_q     <= shape_d;
         amp_q       <= act_q.amp;
         wave_q      <= wave_d;
         en_q        <= {en_q[1:0], enable};
      end
   end

   assign wave_out    = wave_q;
   assign wave_valid  = en_q[2];
   assign cfg_pending = pend_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_waveform_generator.sv
`default_nettype none
// tb_waveform_generator: directed scoreboard bench for the DDS waveform generator.
// Rev 1.0
module tb_waveform_generator;
   import waveform_pkg::*;

   localparam int KW = 0;  // wave_out
   localparam int KR = 1;  // wrap
   localparam int KV = 2;  // wave_valid
   localparam int KP = 3;  // cfg_pending
   localparam logic [25:0] F24 = 26'h100_0000;
   localparam logic [25:0] F25 = 26'h200_0000;
   localparam int TRI_K[9] = '{0, 1, 64, 127, 128, 129, 200, 255, 256};
   localparam int TRI_V[9] = '{0, 2, 128, 254, 255, 253, 111, 1, 0};

   typedef struct {
      int         cyc;
      int         kind;
      logic [7:0] exp;
      string      name;
   } chk_t;

   chk_t sb[$];
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   logic        clk        = 1'b0;
   logic        reset      = 1'b1;
   logic        enable     = 1'b0;
   logic        phase_sync = 1'b0;
   logic        cfg_load   = 1'b0;
   logic [25:0] frequency  = '0;
   logic [7:0]  amplitude  = '0;
   logic [1:0]  mode       = '0;
   logic [7:0]  duty       = '0;
   logic [7:0]  wave_out;
   logic        wave_valid, wrap, cfg_pending;

   waveform_generator #(
      .ACC_WIDTH (32),
      .FREQ_WIDTH(26),
      .OUT_WIDTH (8),
      .AMP_WIDTH (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .phase_sync (phase_sync),
      .cfg_load   (cfg_load),
      .frequency  (frequency),
      .amplitude  (amplitude),
      .mode       (mode),
      .duty       (duty),
      .wave_out   (wave_out),
      .wave_valid (wave_valid),
      .wrap       (wrap),
      .cfg_pending(cfg_pending)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] observe(input int kind);
      case (kind)
         KW:      return wave_out;
         KR:      return {7'd0, wrap};
         KV:      return {7'd0, wave_valid};
         default: return {7'd0, cfg_pending};
      endcase
   endfunction

   // Monitor: checks every queued expectation whose cycle has arrived.
   always @(negedge clk) begin
      logic [7:0] act;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            act = observe(sb[i].kind);
            n_vec++;
            if (sb[i].cyc < cyc) begin
               n_bad++;
               $display("FAIL %s @cycle %0d: not sampled in time (required %0d)",
                        sb[i].name, sb[i].cyc, sb[i].exp);
            end else if (act !== sb[i].exp) begin
               n_bad++;
               $display("FAIL %s @cycle %0d: actual %0d, required %0d",
                        sb[i].name, sb[i].cyc, act, sb[i].exp);
            end
            sb.delete(i);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete within time limit");
      $fatal(1);
   end

   task automatic expect_at(input int c, input int kind, input int val, input string name);
      chk_t it;
      it.cyc  = c;
      it.kind = kind;
      it.exp  = val[7:0];
      it.name = name;
      sb.push_back(it);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      enable     = 1'b0;
      phase_sync = 1'b0;
      cfg_load   = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Loads a config while stalled, lets it apply, then enables; b is the cycle
   // at which acc=0 and the first enabled add is about to happen.
   task automatic start(input logic [25:0] f, input logic [7:0] a, input logic [1:0] m,
                        input logic [7:0] d, output int b);
      frequency = f;
      amplitude = a;
      mode      = m;
      duty      = d;
      cfg_load  = 1'b1;
      enable    = 1'b0;
      tick();
      cfg_load = 1'b0;
      expect_at(cyc, KP, 1, "load_pending");
      tick();
      enable = 1'b1;
      b      = cyc;
      expect_at(b, KP, 0, "load_applied");
   endtask

   initial begin
      int b, r, b2;

      // Reset state
      tick();
      expect_at(cyc, KW, 0, "rst_wave");
      expect_at(cyc, KR, 0, "rst_wrap");
      expect_at(cyc, KV, 0, "rst_valid");
      expect_at(cyc, KP, 0, "rst_pending");
      reset = 1'b0;
      tick();
      tick();
      expect_at(cyc, KW, 0, "idle_wave");
      expect_at(cyc, KP, 0, "idle_pending");

      // Saw-up full amplitude
      start(F24, 8'd255, MODE_SAW_UP, 8'd128, b);
      expect_at(b + 2, KV, 0, "valid_latency_lo");
      expect_at(b + 3, KV, 1, "valid_latency_hi");
      foreach (TRI_K[i]) expect_at(b + 2 + TRI_K[i], KW, TRI_K[i] % 256, "saw_up");
      expect_at(b + 2 + 254, KW, 254, "saw_up_254");
      expect_at(b + 2 + 257, KW, 1, "saw_up_wrapped");
      expect_at(b + 255, KR, 0, "wrap_before");
      expect_at(b + 256, KR, 1, "wrap_first");
      expect_at(b + 257, KR, 0, "wrap_after");
      expect_at(b + 512, KR, 1, "wrap_second");
      wait_until(b + 514);

      // Amplitude scaling
      do_reset();
      start(F24, 8'd128, MODE_SAW_UP, 8'd128, b);
      expect_at(b + 2, KW, 0, "amp128_p0");
      expect_at(b + 202, KW, 100, "amp128_p200");
      expect_at(b + 257, KW, 128, "amp128_p255");
      wait_until(b + 260);
      do_reset();
      start(F24, 8'd0, MODE_SAW_UP, 8'd128, b);
      expect_at(b + 102, KW, 0, "amp0_p100");
      expect_at(b + 257, KW, 0, "amp0_p255");
      wait_until(b + 260);

      // Triangle
      do_reset();
      start(F24, 8'd255, MODE_TRIANGLE, 8'd128, b);
      foreach (TRI_K[i]) expect_at(b + 2 + TRI_K[i], KW, TRI_V[i], "triangle");
      wait_until(b + 260);

      // Square, duty 64: exactly 64 high samples per period
      do_reset();
      start(F24, 8'd255, MODE_SQUARE, 8'd64, b);
      for (int k = 0; k < 257; k++) expect_at(b + 2 + k, KW, ((k % 256) < 64) ? 255 : 0, "square");
      wait_until(b + 261);

      // Config change mid-period, then simultaneous load and apply
      do_reset();
      start(F24, 8'd255, MODE_SAW_UP, 8'd128, b);
      wait_until(b + 100);
      frequency = F25;
      mode      = MODE_SAW_DOWN;
      cfg_load  = 1'b1;
      expect_at(b + 100, KP, 0, "chg_pend_before");
      expect_at(b + 101, KP, 1, "chg_pend_set");
      expect_at(b + 255, KP, 1, "chg_pend_hold");
      expect_at(b + 256, KP, 0, "chg_pend_applied");
      expect_at(b + 256, KR, 1, "chg_wrap");
      expect_at(b + 102, KW, 100, "chg_old_ramp");
      expect_at(b + 256, KW, 254, "chg_old_254");
      expect_at(b + 257, KW, 255, "chg_old_255");
      expect_at(b + 258, KW, 255, "chg_new_0");
      expect_at(b + 259, KW, 253, "chg_new_1");
      expect_at(b + 260, KW, 251, "chg_new_2");
      tick();
      cfg_load = 1'b0;
      wait_until(b + 300);
      frequency = F25;
      mode      = MODE_SAW_UP;
      cfg_load  = 1'b1;
      tick();
      cfg_load = 1'b0;
      expect_at(b + 301, KP, 1, "dbl_first_pend");
      wait_until(b + 383);
      frequency = F24;
      mode      = MODE_SAW_DOWN;
      cfg_load  = 1'b1;
      expect_at(b + 383, KP, 1, "dbl_pend_pre");
      expect_at(b + 384, KP, 1, "dbl_pend_kept");
      expect_at(b + 384, KR, 1, "dbl_wrap1");
      expect_at(b + 511, KP, 1, "dbl_pend_hold");
      expect_at(b + 512, KP, 0, "dbl_pend_clear");
      expect_at(b + 512, KR, 1, "dbl_wrap2");
      expect_at(b + 385, KW, 1, "dbl_old_last");
      expect_at(b + 386, KW, 0, "dbl_x_0");
      expect_at(b + 387, KW, 2, "dbl_x_1");
      expect_at(b + 513, KW, 254, "dbl_x_last");
      expect_at(b + 514, KW, 255, "dbl_y_0");
      expect_at(b + 515, KW, 254, "dbl_y_1");
      tick();
      cfg_load = 1'b0;
      wait_until(b + 517);

      // phase_sync while running, then with enable low applying pending config
      do_reset();
      start(F24, 8'd255, MODE_SAW_UP, 8'd128, b);
      wait_until(b + 50);
      phase_sync = 1'b1;
      expect_at(b + 50, KR, 0, "sync_wrap_pre");
      expect_at(b + 51, KR, 1, "sync_wrap");
      expect_at(b + 52, KR, 0, "sync_wrap_post");
      expect_at(b + 52, KW, 50, "sync_old");
      expect_at(b + 53, KW, 0, "sync_restart");
      expect_at(b + 54, KW, 1, "sync_ramp1");
      expect_at(b + 60, KW, 7, "sync_ramp7");
      tick();
      phase_sync = 1'b0;
      wait_until(b + 80);
      frequency = F24;
      mode      = MODE_SAW_DOWN;
      cfg_load  = 1'b1;
      tick();
      cfg_load = 1'b0;
      wait_until(b + 90);
      enable     = 1'b0;
      phase_sync = 1'b1;
      expect_at(b + 90, KP, 1, "sync_dis_pend");
      expect_at(b + 91, KP, 0, "sync_dis_applied");
      expect_at(b + 91, KR, 1, "sync_dis_wrap");
      expect_at(b + 92, KW, 39, "sync_dis_old");
      expect_at(b + 93, KW, 255, "sync_dis_new");
      expect_at(b + 100, KW, 255, "sync_dis_steady");
      expect_at(b + 92, KV, 1, "sync_dis_valid_hi");
      expect_at(b + 93, KV, 0, "sync_dis_valid_lo");
      tick();
      phase_sync = 1'b0;
      wait_until(b + 102);

      // Asynchronous reset between edges discards pending config and freezes acc
      do_reset();
      start(F24, 8'd255, MODE_SAW_UP, 8'd128, b);
      wait_until(b + 40);
      frequency = F25;
      mode      = MODE_SAW_DOWN;
      cfg_load  = 1'b1;
      tick();
      cfg_load = 1'b0;
      expect_at(b + 41, KP, 1, "ar_pend_set");
      expect_at(b + 59, KW, 57, "ar_running");
      wait_until(b + 60);
      expect_at(b + 60, KW, 0, "ar_wave");
      expect_at(b + 60, KV, 0, "ar_valid");
      expect_at(b + 60, KR, 0, "ar_wrap");
      expect_at(b + 60, KP, 0, "ar_pend");
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      r     = cyc;
      expect_at(r + 3, KW, 0, "ar_post_wave");
      expect_at(r + 3, KP, 0, "ar_post_pend");
      expect_at(r + 3, KR, 0, "ar_post_wrap");
      wait_until(r + 5);
      start(F24, 8'd255, MODE_SAW_UP, 8'd128, b2);
      expect_at(b2 + 2, KW, 0, "ar_resume_0");
      expect_at(b2 + 3, KW, 1, "ar_resume_1");
      expect_at(b2 + 12, KW, 10, "ar_resume_10");
      wait_until(b2 + 14);

      for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
      foreach (sb[i]) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s @cycle %0d: never checked (required %0d)", sb[i].name, sb[i].cyc, sb[i].exp);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/waveform_generator.md
Name: waveform_generator

Overview:
- Parametrised successor to the board's single-mode sawtooth DDS.
- Phase-accumulator synthesiser with four selectable shapes: saw-up, saw-down, triangle, and square with programmable duty.
- Linear amplitude scaling with exact full scale.
- Configuration is double-buffered, so frequency, shape and amplitude changes take effect glitch-free at a period boundary.
- Output feeds the PWM/audio DAC path; the wrap pulse drives scope triggers and LED/debug counters.

Parameters:
- ACC_WIDTH, 32, phase accumulator width.
- FREQ_WIDTH, 23, tuning word width (zero-extended into the accumulator); must be <= ACC_WIDTH.
- OUT_WIDTH, 8, sample width; must be <= ACC_WIDTH-1.
- AMP_WIDTH, 8, amplitude word width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  accumulator advances when high; holds phase when low
- phase_sync  in  1  single-cycle pulse; clears the phase to 0 on the next edge
- cfg_load  in  1  single-cycle pulse; captures frequency/amplitude/mode/duty into the pending register
- frequency  in  FREQ_WIDTH  tuning word; phase increment per clk
- amplitude  in  AMP_WIDTH  gain; all-ones = unity
- mode  in  2  0 saw-up, 1 saw-down, 2 triangle, 3 square
- duty  in  OUT_WIDTH  square high threshold
- wave_out  out  OUT_WIDTH  scaled sample
- wave_valid  out  1  wave_out reflects an enabled phase
- wrap  out  1  one-cycle pulse on accumulator carry-out or phase_sync
- cfg_pending  out  1  pending configuration not yet applied

Behaviour:
- Reset is async, active-high. It clears:
  - acc = 0
  - active config: freq=0, amp=0, mode=0, duty=2^(OUT_WIDTH-1)
  - pending config and cfg_pending = 0
  - pipeline registers, wave_out=0, wave_valid=0, wrap=0
- Reset mid-operation discards any pending config.
- Accumulator, priority order per edge:
  - phase_sync: acc <= 0.
  - else if enable: acc <= acc + active_freq, mod 2^ACC_WIDTH.
  - else: hold.
- carry = unsigned carry-out of that add (enable only).
- wrap <= carry | phase_sync, registered, so it appears in the same cycle acc shows its post-wrap value.
- Config buffering:
  - cfg_load: pending <= inputs, cfg_pending <= 1.
  - apply condition = cfg_pending & (carry | phase_sync | !enable).
  - On apply: active <= pending, cfg_pending <= 0. The new increment is used from the first add after the wrap.
  - Simultaneous cfg_load and apply: active takes the OLD pending, pending takes the new inputs, cfg_pending stays 1.
  - cfg_load with cfg_pending=0 and enable=0: applied on the following edge.
- Shaping, stage 1 (registered from acc; N=OUT_WIDTH):
  - P = acc[ACC_WIDTH-1 -: N]
  - T = acc[ACC_WIDTH-2 -: N]
  - saw-up: P
  - saw-down: ~P
  - triangle: acc[ACC_WIDTH-1] ? ~T : T
  - square: (P < duty) ? all-ones : 0. duty=0 gives constant 0; duty=all-ones gives high for P<max only.
- Scaling, stage 2 (registered):
  - wave_out <= (shape * (amp + 1)) >> AMP_WIDTH.
  - amp+1 is computed in AMP_WIDTH+1 bits, so there is no overflow.
  - amp=all-ones gives exactly shape; amp=0 gives 0 for N <= AMP_WIDTH.
  - Any post-scaling offset/+1 is forbidden: no wrap to 0 at full scale.
- Latency: acc change to wave_out is 2 clk. The mode/amp used is the value active at the shaping/scaling stage respectively; both stages sample active config aligned with acc (pipeline the amp alongside shape).
- wave_valid = enable delayed 3 clk; cleared by reset.
- Disabled: acc holds, the pipeline keeps recomputing the held phase, and wave_out is steady.

Decomposition:
- Package waveform_pkg: MODE_SAW_UP=2'd0, MODE_SAW_DOWN=2'd1, MODE_TRIANGLE=2'd2, MODE_SQUARE=2'd3; a cfg struct/typedef (freq, amp, mode, duty) reused by pending/active registers.
- Sub-module phase_accumulator (ACC_WIDTH, FREQ_WIDTH): accumulator, carry, phase_sync, wrap register.
- Shaping, scaling and config buffering stay in the top module.

Test Plan:
- Saw-up, freq=2^24, amp=255, enable from reset: wave_out steps 0,1,2,…,255,0 one per clk after 2-cycle latency; wrap every 256 clk; wave_valid high 3 clk after enable.
- Amplitude 128, saw-up with P=200: wave_out=(200*129)>>8=100. amp=255 at P=255: 255 (no wrap to 0). amp=0: constant 0.
- Triangle, freq=2^24, amp=255: output rises 0,2,…,254 then falls 255,253,…,1; period 256 clk. Square duty=64: exactly 64 clk high (255), 192 clk low (0) per period.
- cfg_load at P≈100 changing freq 2^24→2^25 and mode→saw-down: cfg_pending=1 until the next wrap; old ramp continues to 255; after the wrap the sequence is 255,253,…; cfg_pending drops on the apply edge. A second cfg_load on the apply cycle leaves cfg_pending=1.
- phase_sync mid-period: next acc=0, wrap pulses, output resumes from shape(0) two cycles later; phase_sync with enable=0 also clears and applies pending.
- Async reset asserted mid-period between clk edges: all outputs 0 immediately, without waiting for a clk edge; cfg_pending=0; after release, the accumulator stays at 0 until a new cfg_load is applied.
